// File: rtl/qam16_demap_serial.sv
// qam16_demap_serial
//
// Demaps registered QAM16 I/Q decision codes to 4-bit symbols. Each symbol
// is held in a 4-deep FIFO and then sent out as a paced serial bit stream,
// MSB first.
//
// Build option:
//   GRAY_MAP_EN  defined   -> Gray demap per axis: -3->00, -1->01, +1->11, +3->10
//                undefined -> natural binary:      -3->00, -1->01, +1->10, +3->11
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   bitsync    in   one-cycle symbol strobe (same strobe as the decision stage)
//   i, q       in   3-bit decided level codes: 101=-3, 111=-1, 001=+1, 011=+3
//   dout       out  serial data bit, held for the whole bit period
//   dout_vld   out  one-cycle pulse at the start of each bit period
//   sym_start  out  high with dout_vld on the MSB of each symbol
//   fifo_lvl   out  FIFO occupancy 0..4 (registered)
//   ovf        out  sticky overflow, set when a symbol is dropped
//
// Serializer states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no symbol in flight; dout holds last bit; load when FIFO non-empty
//   ST_SHIFT | streaming a symbol; div/bit down-counters pace the bits

module qam16_demap_serial #(
    parameter int CLK_PER_BIT = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bitsync,
    input  logic [2:0] i,
    input  logic [2:0] q,
    output logic       dout,
    output logic       dout_vld,
    output logic       sym_start,
    output logic [2:0] fifo_lvl,
    output logic       ovf
);

    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [5:0] DIV_LAST = 6'(CLK_PER_BIT - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic             r_sync_d;
    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [2:0]       r_lvl;
    logic             r_ovf;

    logic [0:0]       r_state;
    logic [5:0]       r_div;
    logic [1:0]       r_bit;
    logic [3:0]       r_shift;
    logic             r_dout;
    logic             r_dout_vld;
    logic             r_sym_start;

    logic             w_empty;
    logic             w_full;
    logic             w_sym_end;
    logic             w_pop;
    logic             w_push;
    logic [3:0]       w_wr_sym;
    logic [3:0]       w_rd_sym;
    logic             w_unused_code0;

    // Only sign (bit 2) and magnitude (bit 1) carry information; bit 0 is
    // redundant in the level code, so the reset code 000 demaps as +1.
    function automatic logic [1:0] demap(input logic [2:0] code);
        logic s;
        logic m;
        s = code[2];
        m = code[1];
`ifdef GRAY_MAP_EN
        return {~s, ~(s ^ m)};
`else
        return {~s, m};
`endif
    endfunction

    assign w_unused_code0 = i[0] ^ q[0];

    assign w_wr_sym = {demap(i), demap(q)};
    assign w_rd_sym = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // The last bit period of a symbol ends when both down-counters hit zero.
    assign w_sym_end = (r_state == ST_SHIFT) && (r_div == 6'd0) && (r_bit == 2'd0);
    assign w_pop     = !w_empty && ((r_state == ST_IDLE) || w_sym_end);

    // A full FIFO still accepts a write if the serializer pops on the same edge.
    assign w_push    = r_sync_d && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_wr_sym;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_d    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lvl       <= 3'd0;
            r_ovf       <= 1'b0;
            r_state     <= ST_IDLE;
            r_div       <= 6'd0;
            r_bit       <= 2'd0;
            r_shift     <= 4'd0;
            r_dout      <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_sym_start <= 1'b0;
        end else begin
            r_sync_d <= bitsync;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + 3'd1;
                2'b01:   r_lvl <= r_lvl - 3'd1;
                default: r_lvl <= r_lvl;
            endcase

            if (r_sync_d && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end

            r_dout_vld  <= 1'b0;
            r_sym_start <= 1'b0;

            if (w_pop) begin
                r_shift     <= {w_rd_sym[2:0], 1'b0};
                r_dout      <= w_rd_sym[3];
                r_dout_vld  <= 1'b1;
                r_sym_start <= 1'b1;
                r_div       <= DIV_LAST;
                r_bit       <= 2'd3;
                r_state     <= ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                if (r_div != 6'd0) begin
                    r_div <= r_div - 1'b1;
                end else if (r_bit != 2'd0) begin
                    r_dout     <= r_shift[3];
                    r_shift    <= {r_shift[2:0], 1'b0};
                    r_dout_vld <= 1'b1;
                    r_bit      <= r_bit - 1'b1;
                    r_div      <= DIV_LAST;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign sym_start = r_sym_start;
    assign fifo_lvl  = r_lvl;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_qam16_demap_serial.sv
// Directed bench for qam16_demap_serial: instance A runs at CLK_PER_BIT=4,
// instance B at CLK_PER_BIT=1. Expected symbols come from hand-written
// per-axis tables for whichever mapping is built.

module tb_qam16_demap_serial;

    logic       clk;
    logic       rst;
    logic       a_bitsync;
    logic       b_bitsync;
    logic [2:0] i;
    logic [2:0] q;

    logic       a_dout, a_vld, a_ss, a_ovf;
    logic [2:0] a_lvl;
    logic       b_dout, b_vld, b_ss, b_ovf;
    logic [2:0] b_lvl;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit qa_bit[$];
    bit qa_ss[$];
    int qa_cyc[$];
    bit qb_bit[$];
    bit qb_ss[$];
    int qb_cyc[$];

    localparam logic [2:0] CODE [4] = '{3'b101, 3'b111, 3'b001, 3'b011};
`ifdef GRAY_MAP_EN
    localparam logic [1:0] AX [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    localparam logic [1:0] AX [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif

    qam16_demap_serial #(.CLK_PER_BIT(4), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .bitsync(a_bitsync), .i(i), .q(q),
        .dout(a_dout), .dout_vld(a_vld), .sym_start(a_ss),
        .fifo_lvl(a_lvl), .ovf(a_ovf)
    );

    qam16_demap_serial #(.CLK_PER_BIT(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .bitsync(b_bitsync), .i(i), .q(q),
        .dout(b_dout), .dout_vld(b_vld), .sym_start(b_ss),
        .fifo_lvl(b_lvl), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_vld) begin
            qa_bit.push_back(a_dout);
            qa_ss.push_back(a_ss);
            qa_cyc.push_back(cyc);
        end
        if (b_vld) begin
            qb_bit.push_back(b_dout);
            qb_ss.push_back(b_ss);
            qb_cyc.push_back(cyc);
        end
    end

    function automatic logic [3:0] nib_a(input int idx);
        return {qa_bit[idx], qa_bit[idx+1], qa_bit[idx+2], qa_bit[idx+3]};
    endfunction

    function automatic logic [3:0] nib_b(input int idx);
        return {qb_bit[idx], qb_bit[idx+1], qb_bit[idx+2], qb_bit[idx+3]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe bitsync for one edge on instance A; returns at the negedge after it.
    task automatic send_a(input logic [2:0] ci, input logic [2:0] cq);
        i = ci; q = cq; a_bitsync = 1'b1;
        @(negedge clk);
        a_bitsync = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] ci, input logic [2:0] cq);
        i = ci; q = cq; b_bitsync = 1'b1;
        @(negedge clk);
        b_bitsync = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; a_bitsync = 1'b0; b_bitsync = 1'b0; i = 3'b000; q = 3'b000;
        idle(2);
        checks++;
        if ({a_dout, a_vld, a_ss, a_lvl, a_ovf} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a got %b exp 0000000", {a_dout, a_vld, a_ss, a_lvl, a_ovf});
        end
        checks++;
        if ({b_dout, b_vld, b_ss, b_lvl, b_ovf} !== 7'b0) begin
            errors++;
            $display("FAIL reset_b got %b exp 0000000", {b_dout, b_vld, b_ss, b_lvl, b_ovf});
        end
        rst = 1'b0;
        idle(4);
        checks++;
        if ({a_vld, a_lvl} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got vld/lvl %b exp 0000", {a_vld, a_lvl});
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_sym;
        logic       exp_v;
        int         bi;
        exp_sym = {AX[3], AX[0]};
        send_a(3'b011, 3'b101);
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) @(negedge clk);
            exp_v = (k == 2) || (k == 6) || (k == 10) || (k == 14);
            checks++;
            if (a_vld !== exp_v) begin
                errors++;
                $display("FAIL single_vld k=%0d got %b exp %b", k, a_vld, exp_v);
            end
            checks++;
            if (a_ss !== (k == 2)) begin
                errors++;
                $display("FAIL single_sym_start k=%0d got %b exp %b", k, a_ss, (k == 2));
            end
            if (exp_v) begin
                bi = 3 - (k - 2) / 4;
                checks++;
                if (a_dout !== exp_sym[bi]) begin
                    errors++;
                    $display("FAIL single_bit k=%0d got %b exp %b", k, a_dout, exp_sym[bi]);
                end
            end
        end
        checks++;
        if (a_dout !== exp_sym[0]) begin
            errors++;
            $display("FAIL single_hold got %b exp %b", a_dout, exp_sym[0]);
        end
    endtask

    task automatic test_all16;
        int         base;
        int         bad_gap;
        int         bad_ss;
        logic [2:0] maxl;
        logic [2:0] flip;
        logic [3:0] exp_sym;
        base = qa_bit.size();
        maxl = 3'd0;
        for (int k = 0; k < 16; k++) begin
            flip = 3'(k % 2);
            send_a(CODE[k / 4] ^ flip, CODE[k % 4] ^ flip);
            for (int c = 0; c < 15; c++) begin
                if (a_lvl > maxl) maxl = a_lvl;
                @(negedge clk);
            end
        end
        idle(10);
        checks++;
        if (qa_bit.size() - base != 64) begin
            errors++;
            $display("FAIL all16_count got %0d exp 64", qa_bit.size() - base);
        end
        checks++;
        if (maxl > 3'd1) begin
            errors++;
            $display("FAIL all16_max_lvl got %0d exp <=1", maxl);
        end
        bad_gap = 0;
        bad_ss  = 0;
        for (int j = 0; j < 64; j++) begin
            if (j > 0 && qa_cyc[base+j] - qa_cyc[base+j-1] != 4) bad_gap++;
            if (qa_ss[base+j] != (j % 4 == 0)) bad_ss++;
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL all16_gapless got %0d bad spacings exp 0", bad_gap);
        end
        checks++;
        if (bad_ss != 0) begin
            errors++;
            $display("FAIL all16_sym_start got %0d bad flags exp 0", bad_ss);
        end
        for (int k = 0; k < 16; k++) begin
            exp_sym = {AX[k / 4], AX[k % 4]};
            checks++;
            if (nib_a(base + 4 * k) !== exp_sym) begin
                errors++;
                $display("FAIL all16_sym k=%0d got %b exp %b", k, nib_a(base + 4 * k), exp_sym);
            end
        end
    endtask

    task automatic test_simultaneous;
        int         base;
        logic [3:0] exp_sym;
        base = qa_bit.size();
        for (int k = 0; k < 5; k++) begin
            send_a(CODE[k % 4], CODE[(k + 2) % 4]);
            if (k < 4) idle(1);
        end
        idle(8);
        send_a(CODE[1], CODE[1]);
        checks++;
        if (a_lvl !== 3'd4) begin
            errors++;
            $display("FAIL simul_lvl_before got %0d exp 4", a_lvl);
        end
        @(negedge clk);
        checks++;
        if (a_lvl !== 3'd4) begin
            errors++;
            $display("FAIL simul_lvl_after got %0d exp 4", a_lvl);
        end
        checks++;
        if (a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL simul_ovf got %b exp 0", a_ovf);
        end
        idle(110);
        checks++;
        if (qa_bit.size() - base != 24) begin
            errors++;
            $display("FAIL simul_count got %0d exp 24", qa_bit.size() - base);
        end
        for (int k = 0; k < 6; k++) begin
            exp_sym = (k < 5) ? {AX[k % 4], AX[(k + 2) % 4]} : {AX[1], AX[1]};
            checks++;
            if (nib_a(base + 4 * k) !== exp_sym) begin
                errors++;
                $display("FAIL simul_sym k=%0d got %b exp %b", k, nib_a(base + 4 * k), exp_sym);
            end
        end
    endtask

    task automatic test_burst;
        int         base;
        logic [3:0] exp_sym;
        int         ii [6] = '{0, 1, 2, 3, 1, 2};
        int         qq [6] = '{1, 2, 3, 0, 3, 0};
        base = qa_bit.size();
        for (int k = 0; k < 6; k++) begin
            send_a(CODE[ii[k]], CODE[qq[k]]);
            if (k < 5) idle(1);
        end
        @(negedge clk);
        checks++;
        if (a_lvl !== 3'd4) begin
            errors++;
            $display("FAIL burst_lvl got %0d exp 4", a_lvl);
        end
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL burst_ovf got %b exp 1", a_ovf);
        end
        idle(90);
        checks++;
        if (qa_bit.size() - base != 20) begin
            errors++;
            $display("FAIL burst_count got %0d exp 20", qa_bit.size() - base);
        end
        for (int k = 0; k < 5; k++) begin
            exp_sym = {AX[ii[k]], AX[qq[k]]};
            checks++;
            if (nib_a(base + 4 * k) !== exp_sym) begin
                errors++;
                $display("FAIL burst_sym k=%0d got %b exp %b", k, nib_a(base + 4 * k), exp_sym);
            end
        end
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL burst_ovf_sticky got %b exp 1", a_ovf);
        end
    endtask

    task automatic test_reset_midstream;
        int base;
        for (int k = 0; k < 3; k++) begin
            send_a(CODE[3], CODE[k]);
            idle(1);
        end
        idle(6);
        rst = 1'b1;
        #1;
        checks++;
        if ({a_dout, a_vld, a_ss, a_lvl, a_ovf} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b exp 0000000", {a_dout, a_vld, a_ss, a_lvl, a_ovf});
        end
        idle(2);
        rst = 1'b0;
        base = qa_bit.size();
        idle(30);
        checks++;
        if (qa_bit.size() - base != 0) begin
            errors++;
            $display("FAIL midrst_no_vld got %0d strobes exp 0", qa_bit.size() - base);
        end
        send_a(CODE[2], CODE[1]);
        idle(2);
        checks++;
        if ({a_vld, a_ss, a_dout} !== {2'b11, AX[2][1]}) begin
            errors++;
            $display("FAIL midrst_restart got %b exp %b", {a_vld, a_ss, a_dout}, {2'b11, AX[2][1]});
        end
        idle(20);
    endtask

    task automatic test_cpb1;
        int         base;
        int         bad_gap;
        int         bad_ss;
        logic [3:0] exp_sym;
        base = qb_bit.size();
        for (int k = 0; k < 4; k++) begin
            send_b(CODE[(k + 1) % 4], CODE[3 - k]);
            idle(3);
        end
        idle(10);
        checks++;
        if (qb_bit.size() - base != 16) begin
            errors++;
            $display("FAIL cpb1_count got %0d exp 16", qb_bit.size() - base);
        end
        bad_gap = 0;
        bad_ss  = 0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0 && qb_cyc[base+j] - qb_cyc[base+j-1] != 1) bad_gap++;
            if (qb_ss[base+j] != (j % 4 == 0)) bad_ss++;
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL cpb1_continuous got %0d bad spacings exp 0", bad_gap);
        end
        checks++;
        if (bad_ss != 0) begin
            errors++;
            $display("FAIL cpb1_sym_start got %0d bad flags exp 0", bad_ss);
        end
        for (int k = 0; k < 4; k++) begin
            exp_sym = {AX[(k + 1) % 4], AX[3 - k]};
            checks++;
            if (nib_b(base + 4 * k) !== exp_sym) begin
                errors++;
                $display("FAIL cpb1_sym k=%0d got %b exp %b", k, nib_b(base + 4 * k), exp_sym);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all16();
        test_simultaneous();
        test_burst();
        test_reset_midstream();
        test_cpb1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam16_demap_serial.md
# qam16_demap_serial

Downstream neighbour of the symbol decision stage in the QAM16 receiver. Takes the registered 3-bit I/Q level codes produced once per symbol, demaps each pair to a 4-bit symbol, buffers symbols in a 4-deep FIFO and serializes them MSB-first into a paced bit stream with a per-bit valid strobe. Sits between the decision stage and the descrambler / frame-sync logic.

## Interface
Parameters:
- CLK_PER_BIT, 4: clk cycles per output bit; legal 1..64; symbol period (bitsync spacing) must be >= 4*CLK_PER_BIT for lossless operation.
- FIFO_DEPTH, 4: symbol FIFO depth; fixed at 4 (power of two, 2-bit pointers plus wrap bit).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- bitsync  in  1  one-cycle symbol strobe, same signal that drives the decision stage.
- i  in  3  decided I level code: 101=-3, 111=-1, 001=+1, 011=+3.
- q  in  3  decided Q level code, same encoding.
- dout  out  1  serial data bit, held for the whole bit period.
- dout_vld  out  1  one-cycle pulse at the start of each bit period.
- sym_start  out  1  high together with dout_vld on bit 3 (MSB) of each symbol.
- fifo_lvl  out  3  current FIFO occupancy 0..4.
- ovf  out  1  sticky overflow flag; cleared only by rst.

## Operation
- Capture: decision outputs update on the edge where bitsync is sampled high, so the block registers bitsync into sync_d and writes {i,q} on the following edge (sync_d=1).
- Demap uses code[2] (s, sign) and code[1] (m, magnitude) only; code[0] ignored; reset code 000 maps as +1.
- Per axis 2 bits {b1,b0}: b1 = ~s; b0 per Configuration.
- Symbol = {I_b1, I_b0, Q_b1, Q_b0}; serialized bit 3 first.
- FIFO: write on sync_d; read when serializer loads. Full + write + no read -> symbol dropped, ovf set to 1. Full + write + read same edge -> write accepted, level stays 4. Empty + write: no bypass; symbol readable next edge.
- Serializer FSM:
  - IDLE: if FIFO non-empty, pop, load shift register, dout=bit3, dout_vld=1, sym_start=1 -> SHIFT.
  - SHIFT: div counter 0..CLK_PER_BIT-1, bit counter 0..3. On div wrap, advance bit: dout=next bit, dout_vld=1. After bit 0 period ends: FIFO non-empty -> pop and load immediately (gapless, same rules as IDLE load); else -> IDLE.
- dout_vld and sym_start are zero on all other cycles; dout holds last bit in IDLE.

## Timing
- Reset values: dout=0, dout_vld=0, sym_start=0, fifo_lvl=0, ovf=0, sync_d=0, FSM=IDLE, pointers and counters 0.
- bitsync high at edge n -> FIFO write at edge n+1 -> load at edge n+2 (FIFO was empty, FSM IDLE) -> first dout_vld/sym_start visible in cycle after edge n+2. Latency 2 edges.
- Bit k of a symbol (k=0 for MSB) strobes after edge L+k*CLK_PER_BIT, L = load edge; next load edge L+4*CLK_PER_BIT.
- CLK_PER_BIT=1: dout_vld constantly high while streaming.
- rst mid-symbol: partial symbol and FIFO contents discarded, outputs to reset values immediately.
- fifo_lvl registered, reflects state after each edge.

## Configuration
- GRAY_MAP_EN defined: Gray demap, b0 = ~(s ^ m): -3->00, -1->01, +1->11, +3->10.
- GRAY_MAP_EN undefined: natural binary, b0 = m: -3->00, -1->01, +1->10, +3->11.
- Same FIFO, FSM and timing in both builds.

## Test plan
- Reset: assert rst mid-stream -> all outputs 0 within same cycle, no dout_vld after release until next bitsync.
- Single symbol, CLK_PER_BIT=4, i=011, q=101, bitsync at edge n: Gray build -> bits 1,0,0,0 with dout_vld after edges n+2, n+6, n+10, n+14, sym_start only on first; natural build -> 1,1,0,0.
- All 16 i/q combinations at bitsync period 16 -> gapless stream, each 4-bit group matches mapping, fifo_lvl never exceeds 1.
- Burst: 6 bitsync pulses 2 cycles apart with CLK_PER_BIT=4 -> fifo_lvl reaches 4, ovf=1, exactly the symbols that found FIFO full and not read are missing, rest output in order.
- Simultaneous: FIFO full and write on the serializer pop edge -> no ovf, fifo_lvl stays 4.
- CLK_PER_BIT=1 with bitsync every 4 cycles -> dout_vld continuously high, sym_start every 4th cycle.
